// File: rtl/xtl_clock_monitor.sv
// Crystal clock frequency monitor: counts synchronized XTL_CLK rising edges over
// back-to-back CLK windows and qualifies or flags the crystal against a tolerance band.
module xtl_clock_monitor #(
   parameter int WINDOW_CYCLES = 5000,
   parameter int EXP_EDGES     = 2000,
   parameter int TOL           = 20,
   parameter int GOOD_WINDOWS  = 4,
   parameter int CNT_W         = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             XTL_CLK,
   input  logic             ENABLE,
   input  logic             CLR_FAIL,
   output logic             XTL_GOOD,
   output logic             XTL_FAIL,
   output logic [CNT_W-1:0] EDGE_COUNT,
   output logic             COUNT_VALID
);

   localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
   localparam logic [CNT_W-1:0]  WIN_LAST    = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0]  RANGE_LO    = CNT_W'(EXP_EDGES - TOL);
   localparam logic [CNT_W-1:0]  RANGE_HI    = CNT_W'(EXP_EDGES + TOL);
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
   localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(GOOD_WINDOWS);

   generate
      if ((longint'(EXP_EDGES) + longint'(TOL) > (longint'(1) << CNT_W) - 1) ||
          (EXP_EDGES < TOL)) begin : g_param_check
         $error("xtl_clock_monitor: EXP_EDGES/TOL do not fit the CNT_W counter range");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      MEASURE
   } state_t;

   state_t            state;
   logic              sync1;
   logic              sync2;
   logic              sync3;
   logic              rise;
   logic [CNT_W-1:0]  win_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic [CNT_W-1:0]  edge_cnt_inc;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_cnt_inc;
   logic              in_range;
   logic              eval_now;
   logic              fail_set;

   // XTL_CLK is asynchronous: two flops for metastability, a third for edge detection.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= XTL_CLK;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise         = sync2 & ~sync3;
   assign edge_cnt_inc = (rise && (edge_cnt != CNT_MAX)) ? edge_cnt + 1'b1 : edge_cnt;
   assign good_cnt_inc = (good_cnt == GOOD_TARGET) ? good_cnt : good_cnt + 1'b1;
   assign in_range     = (EDGE_COUNT >= RANGE_LO) && (EDGE_COUNT <= RANGE_HI);
   assign eval_now     = (state == MEASURE) && ENABLE && COUNT_VALID;
   // A bad window only counts as a failure once the crystal had been qualified.
   assign fail_set     = eval_now && !in_range && XTL_GOOD;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         win_cnt     <= '0;
         edge_cnt    <= '0;
         good_cnt    <= '0;
         XTL_GOOD    <= 1'b0;
         XTL_FAIL    <= 1'b0;
         EDGE_COUNT  <= '0;
         COUNT_VALID <= 1'b0;
      end else begin
         COUNT_VALID <= 1'b0;
         XTL_FAIL    <= fail_set | (XTL_FAIL & ~CLR_FAIL);
         if (!ENABLE) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            good_cnt <= '0;
            XTL_GOOD <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= MEASURE;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
               end
               MEASURE: begin
                  // A rise on the boundary cycle belongs to the window that is ending.
                  if (win_cnt == WIN_LAST) begin
                     EDGE_COUNT  <= edge_cnt_inc;
                     COUNT_VALID <= 1'b1;
                     win_cnt     <= '0;
                     edge_cnt    <= '0;
                  end else begin
                     win_cnt  <= win_cnt + 1'b1;
                     edge_cnt <= edge_cnt_inc;
                  end
                  if (COUNT_VALID) begin
                     if (in_range) begin
                        good_cnt <= good_cnt_inc;
                        XTL_GOOD <= (good_cnt_inc == GOOD_TARGET);
                     end else begin
                        good_cnt <= '0;
                        XTL_GOOD <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xtl_clock_monitor.sv
// Directed bench for xtl_clock_monitor with shortened windows; the crystal is a phase
// accumulator whose edge count over any full window is exactly inc/8.
module tb_xtl_clock_monitor;

   localparam int W    = 200;
   localparam int EXP  = 25;
   localparam int TOL  = 2;
   localparam int GW   = 4;
   localparam int CW   = 16;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          XTL_CLK;
   logic          ENABLE;
   logic          CLR_FAIL;
   logic          XTL_GOOD;
   logic          XTL_FAIL;
   logic [CW-1:0] EDGE_COUNT;
   logic          COUNT_VALID;

   int inc = 200;
   int acc;
   int n_checks = 0;
   int n_pass = 0;
   int win_no = 0;

   always #5 CLK = ~CLK;

   xtl_clock_monitor #(
      .WINDOW_CYCLES (W),
      .EXP_EDGES     (EXP),
      .TOL           (TOL),
      .GOOD_WINDOWS  (GW),
      .CNT_W         (CW)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .XTL_CLK     (XTL_CLK),
      .ENABLE      (ENABLE),
      .CLR_FAIL    (CLR_FAIL),
      .XTL_GOOD    (XTL_GOOD),
      .XTL_FAIL    (XTL_FAIL),
      .EDGE_COUNT  (EDGE_COUNT),
      .COUNT_VALID (COUNT_VALID)
   );

   // Accumulator modulus 1600: W*inc/1600 = inc/8 rising edges per window.
   initial begin : xtl_gen
      acc     = 0;
      XTL_CLK = 1'b0;
      forever begin
         @(negedge CLK);
         acc     = (acc + inc) % 1600;
         XTL_CLK = (acc >= 800);
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(negedge CLK);
         cycles++;
      end while (!COUNT_VALID && cycles < 2 * W + 10);
      if (!COUNT_VALID) check("valid_timeout", 0, 1);
   endtask

   task automatic end_window(output int cnt);
      cnt = int'(EDGE_COUNT);
      @(negedge CLK);
      win_no++;
      $display("window %0d: edge_count=%0d good=%0b fail=%0b", win_no, cnt, XTL_GOOD, XTL_FAIL);
      check("valid_one_cycle", COUNT_VALID, 0);
   endtask

   task automatic window(output int cnt);
      int c;
      wait_valid(c);
      end_window(cnt);
   endtask

   task automatic run_windows(input int n, input int exp_cnt, input logic exp_good_last,
                              input logic exp_fail);
      int cnt;
      for (int i = 0; i < n; i++) begin
         window(cnt);
         check("win_edge_count", cnt, exp_cnt);
         check("win_good", XTL_GOOD, (i == n - 1) ? exp_good_last : 1'b0);
         check("win_fail", XTL_FAIL, exp_fail);
      end
   endtask

   task automatic restart(input int new_inc);
      ENABLE = 1'b0;
      inc    = new_inc;
      repeat (20) @(negedge CLK);
      ENABLE = 1'b1;
   endtask

   initial begin : main
      int lat;
      int cnt;
      int nv;
      RESET_N  = 1'b0;
      ENABLE   = 1'b0;
      CLR_FAIL = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_good", XTL_GOOD, 0);
      check("rst_fail", XTL_FAIL, 0);
      check("rst_count", EDGE_COUNT, 0);
      check("rst_valid", COUNT_VALID, 0);
      RESET_N = 1'b1;
      repeat (10) @(negedge CLK);
      check("idle_no_valid", COUNT_VALID, 0);

      // Nominal crystal: 25 edges per window, qualified after the 4th window.
      ENABLE = 1'b1;
      wait_valid(lat);
      check("first_latency", lat, W + 1);
      end_window(cnt);
      check("nom_count", cnt, 25);
      check("nom_good_w1", XTL_GOOD, 0);
      run_windows(3, 25, 1'b1, 1'b0);

      // Crystal stops while good.
      inc = 0;
      window(cnt);
      check("stop_count_low", (cnt <= 1), 1);
      check("stop_good", XTL_GOOD, 0);
      check("stop_fail", XTL_FAIL, 1);
      window(cnt);
      check("stopped_count", cnt, 0);

      // Restored crystal requalifies; fail stays sticky.
      inc = 200;
      window(cnt);
      check("restore_in_range", (cnt >= 23 && cnt <= 27), 1);
      check("restore_good_w1", XTL_GOOD, 0);
      run_windows(3, 25, 1'b1, 1'b1);

      // ENABLE drop mid-window while good.
      repeat (50) @(negedge CLK);
      ENABLE = 1'b0;
      @(negedge CLK);
      check("dis_good", XTL_GOOD, 0);
      check("dis_fail_kept", XTL_FAIL, 1);
      nv = 0;
      repeat (2 * W + 20) begin
         @(negedge CLK);
         if (COUNT_VALID) nv++;
      end
      check("dis_no_valid", nv, 0);
      CLR_FAIL = 1'b1;
      @(negedge CLK);
      CLR_FAIL = 1'b0;
      check("clr_fail", XTL_FAIL, 0);

      // Re-enable; three good windows, one bad (19 edges), then requalification.
      ENABLE = 1'b1;
      wait_valid(lat);
      check("reen_latency", lat, W + 1);
      end_window(cnt);
      check("reen_count", cnt, 25);
      run_windows(2, 25, 1'b0, 1'b0);
      inc = 152;
      window(cnt);
      check("bad_out_low", (cnt < 23), 1);
      check("bad_good", XTL_GOOD, 0);
      check("bad_no_fail", XTL_FAIL, 0);
      inc = 200;
      window(cnt);
      check("after_bad_in_range", (cnt >= 23 && cnt <= 27), 1);
      check("after_bad_good_w1", XTL_GOOD, 0);
      run_windows(3, 25, 1'b1, 1'b0);
      CLR_FAIL = 1'b1;
      @(negedge CLK);
      CLR_FAIL = 1'b0;
      check("clr_keeps_good", XTL_GOOD, 1);

      // Band edges: 27 and 23 qualify, 28 never does.
      restart(216);
      run_windows(4, 27, 1'b1, 1'b0);
      restart(224);
      run_windows(4, 28, 1'b0, 1'b0);
      restart(184);
      run_windows(4, 23, 1'b1, 1'b0);

      // Fail set and CLR_FAIL in the same cycle: set wins.
      inc = 400;
      wait_valid(lat);
      CLR_FAIL = 1'b1;
      cnt = int'(EDGE_COUNT);
      @(negedge CLK);
      CLR_FAIL = 1'b0;
      win_no++;
      $display("window %0d: edge_count=%0d good=%0b fail=%0b (CLR_FAIL coincident)",
               win_no, cnt, XTL_GOOD, XTL_FAIL);
      check("coinc_out_high", (cnt > 27), 1);
      check("coinc_fail", XTL_FAIL, 1);
      check("coinc_good", XTL_GOOD, 0);

      // Asynchronous reset mid-window.
      inc = 200;
      repeat (50) @(negedge CLK);
      #2 RESET_N = 1'b0;
      #1;
      check("arst_good", XTL_GOOD, 0);
      check("arst_fail", XTL_FAIL, 0);
      check("arst_count", EDGE_COUNT, 0);
      check("arst_valid", COUNT_VALID, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      wait_valid(lat);
      check("post_rst_latency", lat, W + 1);
      end_window(cnt);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/xtl_clock_monitor.md
Name: xtl_clock_monitor

Overview:
- Downstream consumer of the crystal oscillator output (XTLOSC, 20 MHz).
- Runs on the fabric clock (RC oscillator 50 MHz via CCC) and treats the crystal clock as an asynchronous data input.
- Counts crystal rising edges over fixed back-to-back windows and declares the crystal good after N consecutive in-tolerance windows.
- Flags a sticky failure when a good crystal drops out of tolerance. System logic uses it to gate crystal-clock switchover and for fault reporting.

Parameters:
- WINDOW_CYCLES, 5000: CLK cycles per measurement window (100 us at 50 MHz).
- EXP_EDGES, 2000: expected crystal rising edges per window (20 MHz x 100 us).
- TOL, 20: allowed +/- deviation from EXP_EDGES, inclusive (1 %).
- GOOD_WINDOWS, 4: consecutive in-range windows required before XTL_GOOD asserts.
- CNT_W, 16: width of the edge and window counters.

Ports:
- CLK  in  1: fabric clock, all logic on rising edge.
- RESET_N  in  1: asynchronous active-low reset.
- XTL_CLK  in  1: crystal oscillator clock, asynchronous to CLK; high and low times must each exceed one CLK period.
- ENABLE  in  1: level; 1 = monitoring active.
- CLR_FAIL  in  1: single-cycle pulse; clears XTL_FAIL.
- XTL_GOOD  out  1: crystal frequency qualified.
- XTL_FAIL  out  1: sticky; loss of a previously good crystal.
- EDGE_COUNT  out  CNT_W: edge count of the last completed window.
- COUNT_VALID  out  1: one-cycle pulse when EDGE_COUNT updates.

Behaviour:
- Reset values: XTL_GOOD=0, XTL_FAIL=0, EDGE_COUNT=0, COUNT_VALID=0; FSM in IDLE; all counters 0 and synchronizer flops 0.

Input capture:
- XTL_CLK goes through a 2-flop synchronizer, then a third flop for edge detection.
- rise = sync2 & ~sync3. Latency from a crystal edge to the counted increment is 3 CLK cycles.

FSM states:
- IDLE: counters held at 0. Transition to MEASURE on the cycle after ENABLE=1 is sampled.
- MEASURE: win_cnt increments each cycle from 0 to WINDOW_CYCLES-1.
  - edge_cnt increments on each rise and saturates at 2^CNT_W-1.
  - At win_cnt==WINDOW_CYCLES-1 (window end):
    - EDGE_COUNT <= edge_cnt + rise (a rise on the boundary cycle belongs to the ending window).
    - edge_cnt <= 0; win_cnt <= 0.
    - COUNT_VALID pulses on the following cycle.
    - Evaluation runs on that same registered value (see Evaluation).
  - Windows run back-to-back with no dead cycles.
- ENABLE=0 in any state: return to IDLE next cycle.
  - Counters and the good-window counter clear; XTL_GOOD clears.
  - XTL_FAIL is retained and no partial window is reported.

Evaluation (the cycle COUNT_VALID is high):
- In range means EXP_EDGES-TOL <= EDGE_COUNT <= EXP_EDGES+TOL.
- In range: good_cnt increments, saturating at GOOD_WINDOWS. XTL_GOOD goes to 1 in the same cycle good_cnt reaches GOOD_WINDOWS.
- Out of range: good_cnt <= 0 and XTL_GOOD <= 0. If XTL_GOOD was 1, XTL_FAIL <= 1.
- An out-of-range window during qualification (XTL_GOOD=0) never sets XTL_FAIL.

XTL_FAIL:
- Cleared by CLR_FAIL.
- If set and clear occur in the same cycle, set wins.
- CLR_FAIL has no other effect.

Other rules:
- A stopped crystal produces EDGE_COUNT=0, which is out of range; the monitor detects it within one window.
- All comparisons are unsigned CNT_W-bit.
- EXP_EDGES+TOL must fit in CNT_W bits, and EXP_EDGES >= TOL; both are elaboration-time requirements.
- Async RESET_N assertion mid-window returns every output and counter to its reset value immediately. Measurement restarts in IDLE after release.

Test Plan:
- 20.000 MHz XTL_CLK, ENABLE=1 from reset release -> COUNT_VALID every 5000 cycles with EDGE_COUNT within 1999..2001; XTL_GOOD=1 after the 4th window, XTL_FAIL=0.
- 20.2 MHz (about 2020 edges) -> in range, XTL_GOOD=1. 20.25 MHz (about 2025 edges) -> XTL_GOOD stays 0 and XTL_FAIL stays 0.
- XTL_GOOD=1, then XTL_CLK held low -> the next window reports EDGE_COUNT=0, XTL_GOOD=0, XTL_FAIL=1. Restoring the clock -> XTL_GOOD returns after 4 windows while XTL_FAIL stays 1 until a CLR_FAIL pulse.
- 3 good windows, 1 bad window (1900 edges), then good windows -> good_cnt restarts; XTL_GOOD asserts only after 4 further good windows (8th window overall after the bad one counts from 0).
- ENABLE dropped mid-window while XTL_GOOD=1 -> XTL_GOOD=0 next cycle, no COUNT_VALID for the partial window, XTL_FAIL unchanged. Re-enable -> first COUNT_VALID 5001 cycles later.
- RESET_N pulsed low mid-window, and CLR_FAIL coincident with a fail-set window -> all outputs return to 0 asynchronously on reset; in the coincident case XTL_FAIL=1 after the cycle.
